serial_add_sequencer: RTL and testbench

// - Bit-serial N-bit adder front end. Sits directly upstream of the 1-bit full-adder cell.
// - Accepts two WIDTH-bit operands plus carry-in over a valid/ready handshake.
// - Feeds the full adder one bit pair per cycle, LSB first, and registers the carry between cycles.
// - Collects the sum bits and returns the WIDTH-bit sum and carry-out over a valid/ready handshake.

---
 rtl/serial_add_sequencer_pkg.sv | 12 +
 rtl/serial_add_sequencer_if.sv | 32 +++
 rtl/serial_add_sequencer_fa_cell.sv | 11 +
 rtl/serial_add_sequencer.sv | 128 ++++++++++++
 tb/tb_serial_add_sequencer.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/serial_add_sequencer_pkg.sv
// Shared types and constants for the bit-serial adder front end.
package serial_add_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_add_sequencer_if.sv
// Operand/result bus for the bit-serial adder.
//
// Handshake rules (both channels): a transfer happens only on a rising
// clock edge where valid && ready are both high. The producer holds
// valid and its data stable until that edge; ready may be sampled
// combinationally but never depends on valid.
interface serial_add_sequencer_if
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
endinterface

// File: rtl/serial_add_sequencer_fa_cell.sv
// One-bit full adder, shared across all bit positions of the serial add.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_add_sequencer.sv
// Bit-serial WIDTH-bit adder: accepts operands, feeds the full-adder cell
// one bit pair per cycle LSB first, then presents {cout,sum} until taken.
module serial_add_sequencer
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
)
(
    input  logic                 clk,
    input  logic                 rst,
    serial_add_sequencer_if.slave bus,
    output state_t               dbg_state
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             fa_s;
    logic             fa_cout;
    logic             last_bit;

    fa_cell u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_cout)
    );

    assign last_bit = (cnt == LAST_CNT);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake outputs; a result handoff in DONE never
    // overlaps with an operand accept, so the new op waits one IDLE edge.
    always_comb begin
        next_state    = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                bus.busy = 1'b1;
                if (last_bit) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                bus.busy      = 1'b1;
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath: load operands, shift one bit pair per cycle, latch the result
    // into dedicated output registers only on the final shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            sum_r  <= '0;
            cout_r <= 1'b0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sr   <= bus.a;
                        b_sr   <= bus.b;
                        carry  <= bus.cin;
                        cnt    <= '0;
                        sum_sr <= '0;
                    end
                end
                SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    carry  <= fa_cout;
                    sum_sr <= {fa_s, sum_sr[WIDTH-1:1]};
                    if (last_bit) begin
                        // Counter parks at zero so it never passes WIDTH-1.
                        cnt    <= '0;
                        sum_r  <= {fa_s, sum_sr[WIDTH-1:1]};
                        cout_r <= fa_cout;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.sum   = sum_r;
    assign bus.cout  = cout_r;
    assign dbg_state = state;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Bench for serial_add_sequencer: directed vectors with literal results, plus
// a cycle-level reference model of the handshake timing and arithmetic.
`timescale 1ns/1ps
module tb_serial_add_sequencer;
    import serial_add_pkg::*;

    localparam int WIDTH    = 8;
    localparam int MAX_WAIT = 200;
    localparam int N_RAND   = 1000;

    // ---------------- clock / reset ----------------
    logic   clk = 1'b0;
    logic   rst = 1'b0;
    state_t dbg_state;

    always #5 clk = ~clk;

    serial_add_sequencer_if #(.WIDTH(WIDTH)) bus ();

    serial_add_sequencer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- counters / check ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The model knows only the contract: an op accepted on edge E0 shows its
    // result from the cycle after edge E0+WIDTH until it is taken; the result
    // registers hold the last completed result (0 after reset).
    int               edge_cnt = 0;
    bit               have_op  = 1'b0;
    int               ready_edge = 0;
    logic [WIDTH:0]   shown = '0;
    logic [WIDTH:0]   exp_q[$];
    int               done_ops = 0;
    bit               track_gaps = 1'b0;
    int               last_accept_edge = -1;
    int               gaps[$];

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Compare process: outputs sampled mid-cycle, inputs are stable here.
    always @(negedge clk) begin
        bit exp_ov;
        if (rst) begin
            have_op = 1'b0;
            shown   = '0;
            exp_q.delete();
            check("rst_in_ready",  64'(bus.in_ready), 64'(1));
            check("rst_out_valid", 64'(bus.out_valid), 64'(0));
            check("rst_busy",      64'(bus.busy), 64'(0));
            check("rst_result",    64'({bus.cout, bus.sum}), 64'(0));
        end else begin
            exp_ov = have_op && (edge_cnt >= ready_edge);
            if (exp_ov) shown = exp_q[0];
            check("in_ready",  64'(bus.in_ready), 64'(!have_op));
            check("busy",      64'(bus.busy), 64'(have_op));
            check("out_valid", 64'(bus.out_valid), 64'(exp_ov));
            check("result",    64'({bus.cout, bus.sum}), 64'(shown));
            // Observed DUT accepts, used for the spacing check.
            if (track_gaps && bus.in_valid && bus.in_ready) begin
                if (last_accept_edge >= 0) gaps.push_back(edge_cnt + 1 - last_accept_edge);
                last_accept_edge = edge_cnt + 1;
            end
            // Model update for the coming edge.
            if (exp_ov && bus.out_ready) begin
                void'(exp_q.pop_front());
                have_op = 1'b0;
                done_ops++;
            end else if (!have_op && bus.in_valid) begin
                have_op    = 1'b1;
                ready_edge = edge_cnt + 1 + WIDTH;
                exp_q.push_back({1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.cin});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c,
                          input logic [WIDTH:0] exp, input int hold);
        int t;
        int lat;
        @(posedge clk); #1;
        bus.a = a; bus.b = b; bus.cin = c; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        t = 0;
        while (!bus.in_ready && t < MAX_WAIT) begin @(posedge clk); #1; t++; end
        check("accept_timeout", 64'(t < MAX_WAIT), 64'(1));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < MAX_WAIT) begin @(posedge clk); #1; lat++; end
        check("latency", 64'(lat), 64'(WIDTH));
        check("sum_literal", 64'({bus.cout, bus.sum}), 64'(exp));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("bp_out_valid", 64'(bus.out_valid), 64'(1));
            check("bp_in_ready",  64'(bus.in_ready), 64'(0));
            check("bp_result",    64'({bus.cout, bus.sum}), 64'(exp));
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("handoff_in_ready",  64'(bus.in_ready), 64'(1));
        check("handoff_out_valid", 64'(bus.out_valid), 64'(0));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #(600_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    bit prod_done = 1'b0;
    int start_ops;

    initial begin
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.out_ready = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("post_rst_in_ready", 64'(bus.in_ready), 64'(1));
        check("post_rst_state",    64'(dbg_state), 64'(IDLE));

        // Directed arithmetic with literal results.
        run_op(8'h3C, 8'h5A, 1'b0, 9'h096, 0);
        run_op(8'hFF, 8'h01, 1'b0, 9'h100, 0);
        run_op(8'hFF, 8'hFF, 1'b1, 9'h1FF, 20);
        run_op(8'h00, 8'h00, 1'b1, 9'h001, 2);

        // in_valid held high with data changing every cycle, consumer always ready.
        @(posedge clk); #1;
        gaps.delete(); last_accept_edge = -1; track_gaps = 1'b1;
        bus.out_ready = 1'b1; bus.in_valid = 1'b1;
        for (int i = 0; i < 45; i++) begin
            bus.a = WIDTH'($urandom); bus.b = WIDTH'($urandom); bus.cin = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        begin
            int t = 0;
            while (bus.busy && t < MAX_WAIT) begin @(posedge clk); #1; t++; end
            check("b2b_drain_timeout", 64'(t < MAX_WAIT), 64'(1));
        end
        track_gaps = 1'b0; bus.out_ready = 1'b0;
        check("b2b_gap_count", 64'(gaps.size() >= 3), 64'(1));
        foreach (gaps[i]) check("b2b_gap", 64'(gaps[i]), 64'(10));

        // Reset in the middle of a shift sequence.
        @(posedge clk); #1;
        bus.a = 8'h0F; bus.b = 8'h01; bus.cin = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("mid_state", 64'(dbg_state), 64'(SHIFT));
        rst = 1'b1;
        #1;
        check("async_rst_state",    64'(dbg_state), 64'(IDLE));
        check("async_rst_busy",     64'(bus.busy), 64'(0));
        check("async_rst_in_ready", 64'(bus.in_ready), 64'(1));
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("after_rst_no_valid", 64'(bus.out_valid), 64'(0));
        check("after_rst_result",   64'({bus.cout, bus.sum}), 64'(0));
        run_op(8'h01, 8'h01, 1'b0, 9'h002, 0);

        // Random ops with random producer gaps and consumer backpressure.
        start_ops = done_ops;
        fork
            begin
                for (int i = 0; i < N_RAND; i++) begin
                    int t;
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    bus.a = WIDTH'($urandom); bus.b = WIDTH'($urandom);
                    bus.cin = 1'($urandom_range(0, 1)); bus.in_valid = 1'b1;
                    t = 0;
                    while (!bus.in_ready && t < MAX_WAIT) begin @(posedge clk); #1; t++; end
                    check("rand_accept_timeout", 64'(t < MAX_WAIT), 64'(1));
                    @(posedge clk); #1;
                    bus.in_valid = 1'b0;
                end
                prod_done = 1'b1;
            end
            begin
                int guard = 0;
                while (!(prod_done && (done_ops - start_ops) == N_RAND) && guard < 40000) begin
                    bus.out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                    guard++;
                end
                bus.out_ready = 1'b0;
            end
        join
        check("rand_ops_done", 64'(done_ops - start_ops), 64'(N_RAND));

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
